updown_step_controller: RTL and testbench



---
 rtl/updown_step_controller.sv | 70 +++++++
 tb/tb_updown_step_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/updown_step_controller.sv
// updown_step_controller: accepts up/down step commands and strobes a counter one step per clock
module updown_step_controller #(
    parameter int WIDTH   = 2,
    parameter int STEPS_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_up,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic               pause,
    input  logic               abort,
    output logic               cnt_en,
    output logic               cnt_up,
    output logic [WIDTH-1:0]   pos,
    output logic [STEPS_W-1:0] remaining,
    output logic               wrap,
    output logic               done,
    output logic               aborted
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic   dir;
    logic   fire;

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next state: a zero-length command goes straight to DONE, abort ends RUN without a step
    always_comb begin
        state_nx = (state == IDLE) ? (fire ? ((cmd_steps != '0) ? RUN : DONE) : IDLE)
                 : (state == RUN)  ? ((abort || (cnt_en && remaining == STEPS_W'(1))) ? DONE : RUN)
                 : IDLE;
    end

    // outputs decoded from state; stepping and acceptance are blocked while reset is high
    always_comb begin
        cmd_ready = !reset && state == IDLE;
        cnt_en    = !reset && state == RUN && !pause && !abort;
        fire      = cmd_valid && cmd_ready;
        cnt_up    = dir;
        done      = state == DONE;
    end

    // command latch, position mirror, wrap pulse and abort flag (abort always lands in DONE next)
    always_ff @(posedge clock) begin
        if (reset) begin
            pos       <= '0;
            remaining <= '0;
            dir       <= 1'b0;
            wrap      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            wrap    <= cnt_en && (dir ? pos == {WIDTH{1'b1}} : pos == '0);
            aborted <= state == RUN && abort;
            if (fire) begin
                dir       <= cmd_up;
                remaining <= cmd_steps;
            end
            if (cnt_en) begin
                pos       <= dir ? pos + WIDTH'(1) : pos - WIDTH'(1);
                remaining <= remaining - STEPS_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_updown_step_controller.sv
// tb_updown_step_controller: table, directed and random checks against a step-count model
module tb_updown_step_controller;
    logic       clock, reset, cmd_valid, cmd_ready, cmd_up, pause, abort;
    logic       cnt_en, cnt_up, wrap, done, aborted;
    logic [3:0] cmd_steps, remaining;
    logic [1:0] pos;

    updown_step_controller #(.WIDTH(2), .STEPS_W(4)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_up(cmd_up), .cmd_steps(cmd_steps), .pause(pause), .abort(abort),
        .cnt_en(cnt_en), .cnt_up(cnt_up), .pos(pos), .remaining(remaining),
        .wrap(wrap), .done(done), .aborted(aborted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       r, v, up;
        logic [3:0] st;
        logic       p, a;
    } in_t;
    typedef struct {
        in_t         i;
        logic [11:0] e;
    } vec_t;

    int n_vec = 0, n_err = 0;
    logic [11:0] o;
    // model: position as an integer, steps left, whether a command is in progress or just finished
    int m_pos, m_left;
    bit m_busy, m_fin, m_ab, m_dir, m_wrap;

    function automatic in_t mk(logic r, logic v, logic up, int st, logic p, logic a);
        return '{r: r, v: v, up: up, st: 4'(st), p: p, a: a};
    endfunction

    // packed outputs: rdy, en, up, pos[2], rem[4], wrap, done, aborted
    function automatic logic [11:0] ex(logic rdy, logic en, logic cu, int ps, int rm, logic wr, logic dn, logic ab);
        return {rdy, en, cu, 2'(ps), 4'(rm), wr, dn, ab};
    endfunction

    function automatic logic [11:0] model_o(in_t x);
        return ex(!x.r && !m_busy && !m_fin, !x.r && m_busy && !x.p && !x.a, m_dir,
                  m_pos, m_left, m_wrap, m_fin, m_fin && m_ab);
    endfunction

    task automatic model_reset();
        m_pos = 0; m_left = 0; m_busy = 0; m_fin = 0; m_ab = 0; m_dir = 0; m_wrap = 0;
    endtask

    task automatic model_step(in_t x);
        int n;
        if (x.r) begin
            model_reset();
        end else begin
            m_wrap = 0;
            if (!m_busy && !m_fin) begin
                if (x.v) begin
                    m_dir = x.up; m_left = int'(x.st); m_busy = x.st != 0; m_fin = x.st == 0; m_ab = 0;
                end
            end else if (m_busy) begin
                if (x.a) begin
                    m_busy = 0; m_fin = 1; m_ab = 1;
                end else if (!x.p) begin
                    n = m_pos + (m_dir ? 1 : -1);
                    m_wrap = n < 0 || n > 3;
                    m_pos = (n + 4) % 4;
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_busy = 0; m_fin = 1; m_ab = 0;
                    end
                end
            end else begin
                m_fin = 0; m_ab = 0;
            end
        end
    endtask

    task automatic chk(string name, logic [11:0] got, logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %03h expected %03h at %0t", name, got, exp, $time);
        end
    endtask

    // one clock: drive at negedge, compare, advance model across the posedge
    task automatic cyc(in_t x, logic [11:0] exp, bit use_exp);
        reset = x.r; cmd_valid = x.v; cmd_up = x.up; cmd_steps = x.st; pause = x.p; abort = x.a;
        #1;
        o = {cmd_ready, cnt_en, cnt_up, pos, remaining, wrap, done, aborted};
        chk("model", o, model_o(x));
        if (use_exp) chk("table", o, exp);
        model_step(x);
        @(negedge clock);
    endtask

    task automatic idle1();
        cyc(mk(0, 0, 0, 0, 0, 0), '0, 0);
    endtask

    vec_t tbl[$];
    int ens, didx, start;

    initial begin
        reset = 1; cmd_valid = 0; cmd_up = 0; cmd_steps = 0; pause = 0; abort = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        model_reset();
        tbl.push_back('{mk(1,0,0,0,0,0), ex(0,0,0,0,0,0,0,0)});
        tbl.push_back('{mk(0,1,1,3,0,0), ex(1,0,0,0,0,0,0,0)});
        tbl.push_back('{mk(0,0,0,0,0,0), ex(0,1,1,0,3,0,0,0)});
        tbl.push_back('{mk(0,0,0,0,0,0), ex(0,1,1,1,2,0,0,0)});
        tbl.push_back('{mk(0,0,0,0,0,0), ex(0,1,1,2,1,0,0,0)});
        tbl.push_back('{mk(0,0,0,0,0,0), ex(0,0,1,3,0,0,1,0)});
        tbl.push_back('{mk(0,1,1,2,0,0), ex(1,0,1,3,0,0,0,0)});
        tbl.push_back('{mk(0,0,0,0,0,0), ex(0,1,1,3,2,0,0,0)});
        tbl.push_back('{mk(0,0,0,0,0,0), ex(0,1,1,0,1,1,0,0)});
        tbl.push_back('{mk(0,0,0,0,0,0), ex(0,0,1,1,0,0,1,0)});
        tbl.push_back('{mk(0,1,0,2,0,0), ex(1,0,1,1,0,0,0,0)});
        tbl.push_back('{mk(0,0,0,0,0,0), ex(0,1,0,1,2,0,0,0)});
        tbl.push_back('{mk(0,0,0,0,0,0), ex(0,1,0,0,1,0,0,0)});
        tbl.push_back('{mk(0,0,0,0,0,0), ex(0,0,0,3,0,1,1,0)});
        tbl.push_back('{mk(0,1,1,0,0,0), ex(1,0,0,3,0,0,0,0)});
        tbl.push_back('{mk(0,0,0,0,0,0), ex(0,0,1,3,0,0,1,0)});
        tbl.push_back('{mk(0,0,0,0,0,0), ex(1,0,1,3,0,0,0,0)});
        foreach (tbl[k]) cyc(tbl[k].i, tbl[k].e, 1);

        // pause for two cycles after the first step
        start = m_pos; ens = 0; didx = -1;
        cyc(mk(0, 1, 1, 4, 0, 0), '0, 0);
        for (int k = 0; k < 8; k++) begin
            cyc(mk(0, 0, 0, 0, k == 1 || k == 2, 0), '0, 0);
            ens += int'(o[10]);
            if (o[1] && didx < 0) didx = k;
        end
        chk("pause_en_count", 12'(ens), 12'd4);
        chk("pause_done_idx", 12'(didx), 12'd6);
        chk("pause_pos", 12'(o[8:7]), 12'(start));

        // pause and abort together: abort wins
        cyc(mk(0, 1, 1, 3, 0, 0), '0, 0);
        idle1();
        cyc(mk(0, 0, 0, 0, 1, 1), '0, 0);
        chk("pa_no_step", 12'(o[10]), 12'd0);
        idle1();
        chk("pa_done_abort", 12'(o[1:0]), 12'd3);
        idle1();

        // abort after two of five steps
        start = m_pos;
        cyc(mk(0, 1, 1, 5, 0, 0), '0, 0);
        idle1();
        idle1();
        cyc(mk(0, 0, 0, 0, 0, 1), '0, 0);
        idle1();
        chk("abort_rem", 12'(o[6:3]), 12'd3);
        chk("abort_flags", 12'(o[1:0]), 12'd3);
        chk("abort_pos", 12'(o[8:7]), 12'((start + 2) % 4));
        idle1();
        cyc(mk(0, 1, 0, 1, 0, 0), '0, 0);
        idle1();
        idle1();
        chk("next_not_aborted", 12'(o[1:0]), 12'd2);
        idle1();

        // reset in the middle of a six-step command
        cyc(mk(0, 1, 1, 6, 0, 0), '0, 0);
        repeat (3) idle1();
        cyc(mk(1, 0, 0, 0, 0, 0), '0, 0);
        chk("rst_outs_low", 12'(o[11:10]), 12'd0);
        idle1();
        chk("rst_state", {o[11], o[8:3], o[1]}, 8'h80);

        // random traffic
        for (int k = 0; k < 800; k++)
            cyc(mk($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, 1'($urandom),
                   $urandom_range(0, 15), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0), '0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
